// File: rtl/pll_drp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_drp_sequencer
// Purpose  : PLL reconfiguration sequencer. A start request puts the PLL in
//            reset and walks N_STEPS table entries, performing a DRP
//            read-modify-write on each. The PLL reset is then released and
//            the sequencer waits for LOCKED before pulsing SRDY.
// Ports    : DCLK/RST        clock, async active-high reset
//            SEN/SSEL        start request and configuration-set select
//            SRDY/BUSY/ERR   done pulse, busy level, sticky timeout flag
//            TBL_IDX         {set, step} index into the external table
//            TBL_ADDR/MASK/DATA  table entry for TBL_IDX (combinational)
//            DADDR/DEN/DWE/DI/DO/DRDY  DRP port
//            LOCKED/RST_PLL  PLL lock indicator and PLL reset
// Revision : 1.0  initial release
// ============================================================================
module pll_drp_sequencer #(
   parameter int N_STEPS = 23,
   parameter int STEP_W  = 5,
   parameter int CFG_W   = 1,
   parameter int TIMEOUT = 255
) (
   input  logic                     DCLK,
   input  logic                     RST,
   input  logic                     SEN,
   input  logic [CFG_W-1:0]         SSEL,
   output logic                     SRDY,
   output logic                     BUSY,
   output logic                     ERR,
   output logic [CFG_W+STEP_W-1:0]  TBL_IDX,
   input  logic [6:0]               TBL_ADDR,
   input  logic [15:0]              TBL_MASK,
   input  logic [15:0]              TBL_DATA,
   output logic [6:0]               DADDR,
   output logic                     DEN,
   output logic                     DWE,
   output logic [15:0]              DI,
   input  logic [15:0]              DO,
   input  logic                     DRDY,
   input  logic                     LOCKED,
   output logic                     RST_PLL
);

   localparam int                c_tmo_w     = $clog2(TIMEOUT + 1);
   localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
   localparam logic [STEP_W-1:0] c_last_step = STEP_W'(N_STEPS - 1);

   typedef enum logic [3:0] {
      ST_WAIT_LOCK = 4'd0,
      ST_IDLE      = 4'd1,
      ST_RD_REQ    = 4'd2,
      ST_RD_WAIT   = 4'd3,
      ST_WR_REQ    = 4'd4,
      ST_WR_WAIT   = 4'd5,
      ST_RELEASE   = 4'd6,
      ST_LOCK_WAIT = 4'd7
   } state_t;

   state_t              state_q,    state_d;
   logic [STEP_W-1:0]   step_q,     step_d;
   logic [CFG_W-1:0]    ssel_q,     ssel_d;
   logic [15:0]         wdata_q,    wdata_d;
   logic [c_tmo_w-1:0]  tmo_q,      tmo_d;
   logic                seen_low_q, seen_low_d;
   logic [6:0]          daddr_q,    daddr_d;
   logic                den_q,      den_d;
   logic                dwe_q,      dwe_d;
   logic [15:0]         di_q,       di_d;
   logic                srdy_q,     srdy_d;
   logic                busy_q,     busy_d;
   logic                err_q,      err_d;
   logic                rst_pll_q,  rst_pll_d;
   logic                w_timed;

   // An undriven or unknown DRDY must never look like a ready DRP.
   logic w_drdy;
   assign w_drdy = (DRDY === 1'b1);

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      ssel_d     = ssel_q;
      wdata_d    = wdata_q;
      tmo_d      = '0;
      seen_low_d = seen_low_q;
      daddr_d    = daddr_q;
      den_d      = 1'b0;
      dwe_d      = dwe_q;
      di_d       = di_q;
      srdy_d     = 1'b0;
      busy_d     = busy_q;
      err_d      = err_q;
      rst_pll_d  = rst_pll_q;
      w_timed    = 1'b0;

      case (state_q)
         ST_WAIT_LOCK: begin
            rst_pll_d = 1'b0;
            if (LOCKED) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (SEN) begin
               ssel_d    = SSEL;
               step_d    = '0;
               err_d     = 1'b0;
               rst_pll_d = 1'b1;
               busy_d    = 1'b1;
               state_d   = ST_RD_REQ;
            end
         end
         ST_RD_REQ: begin
            w_timed = 1'b1;
            if (w_drdy) begin
               den_d      = 1'b1;
               dwe_d      = 1'b0;
               daddr_d    = TBL_ADDR;
               seen_low_d = 1'b0;
               state_d    = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            w_timed = 1'b1;
            // Completion needs DRDY to have dropped at least once since DEN.
            if (!w_drdy) begin
               seen_low_d = 1'b1;
            end else if (seen_low_q) begin
               wdata_d = (DO & TBL_MASK) | (TBL_DATA & ~TBL_MASK);
               state_d = ST_WR_REQ;
            end
         end
         ST_WR_REQ: begin
            w_timed = 1'b1;
            if (w_drdy) begin
               den_d      = 1'b1;
               dwe_d      = 1'b1;
               daddr_d    = TBL_ADDR;
               di_d       = wdata_q;
               seen_low_d = 1'b0;
               state_d    = ST_WR_WAIT;
            end
         end
         ST_WR_WAIT: begin
            w_timed = 1'b1;
            if (!w_drdy) begin
               seen_low_d = 1'b1;
            end else if (seen_low_q) begin
               if (step_q == c_last_step) begin
                  state_d = ST_RELEASE;
               end else begin
                  step_d  = step_q + STEP_W'(1);
                  state_d = ST_RD_REQ;
               end
            end
         end
         ST_RELEASE: begin
            rst_pll_d = 1'b0;
            state_d   = ST_LOCK_WAIT;
         end
         ST_LOCK_WAIT: begin
            w_timed = 1'b1;
            if (LOCKED) begin
               srdy_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_WAIT_LOCK;
         end
      endcase

      // The counter restarts whenever the state changes, so it measures the
      // time spent in the current wait state only. Progress wins over abort.
      if (w_timed && (state_d == state_q)) begin
         if (tmo_q == c_tmo_last) begin
            err_d     = 1'b1;
            rst_pll_d = 1'b0;
            den_d     = 1'b0;
            busy_d    = 1'b0;
            srdy_d    = 1'b0;
            state_d   = ST_IDLE;
         end else begin
            tmo_d = tmo_q + c_tmo_w'(1);
         end
      end
   end

   always_ff @(posedge DCLK or posedge RST) begin
      if (RST) begin
         state_q    <= ST_WAIT_LOCK;
         step_q     <= '0;
         ssel_q     <= '0;
         wdata_q    <= '0;
         tmo_q      <= '0;
         seen_low_q <= 1'b0;
         daddr_q    <= '0;
         den_q      <= 1'b0;
         dwe_q      <= 1'b0;
         di_q       <= '0;
         srdy_q     <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         rst_pll_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         ssel_q     <= ssel_d;
         wdata_q    <= wdata_d;
         tmo_q      <= tmo_d;
         seen_low_q <= seen_low_d;
         daddr_q    <= daddr_d;
         den_q      <= den_d;
         dwe_q      <= dwe_d;
         di_q       <= di_d;
         srdy_q     <= srdy_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         rst_pll_q  <= rst_pll_d;
      end
   end

   assign TBL_IDX = {ssel_q, step_q};
   assign DADDR   = daddr_q;
   assign DEN     = den_q;
   assign DWE     = dwe_q;
   assign DI      = di_q;
   assign SRDY    = srdy_q;
   assign BUSY    = busy_q;
   assign ERR     = err_q;
   assign RST_PLL = rst_pll_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_drp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_drp_sequencer
// Purpose  : Directed bench for pll_drp_sequencer with a two-entry table per
//            configuration set, a small DRP responder and a lock driver.
// Revision : 1.0  initial release
// ============================================================================
module tb_pll_drp_sequencer;

   localparam int N_STEPS = 2;
   localparam int STEP_W  = 5;
   localparam int CFG_W   = 1;
   localparam int TIMEOUT = 255;
   localparam int IDX_W   = CFG_W + STEP_W;

   logic              DCLK   = 1'b0;
   logic              RST    = 1'b1;
   logic              SEN    = 1'b0;
   logic [CFG_W-1:0]  SSEL   = '0;
   logic              LOCKED = 1'b0;
   logic              DRDY   = 1'b1;
   logic [15:0]       DO     = '0;
   logic              SRDY, BUSY, ERR, DEN, DWE, RST_PLL;
   logic [IDX_W-1:0]  TBL_IDX;
   logic [6:0]        TBL_ADDR, DADDR;
   logic [15:0]       TBL_MASK, TBL_DATA, DI;

   int checks = 0;
   int errors = 0;

   pll_drp_sequencer #(
      .N_STEPS (N_STEPS),
      .STEP_W  (STEP_W),
      .CFG_W   (CFG_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .DCLK     (DCLK),
      .RST      (RST),
      .SEN      (SEN),
      .SSEL     (SSEL),
      .SRDY     (SRDY),
      .BUSY     (BUSY),
      .ERR      (ERR),
      .TBL_IDX  (TBL_IDX),
      .TBL_ADDR (TBL_ADDR),
      .TBL_MASK (TBL_MASK),
      .TBL_DATA (TBL_DATA),
      .DADDR    (DADDR),
      .DEN      (DEN),
      .DWE      (DWE),
      .DI       (DI),
      .DO       (DO),
      .DRDY     (DRDY),
      .LOCKED   (LOCKED),
      .RST_PLL  (RST_PLL)
   );

   always #5 DCLK = ~DCLK;

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // External configuration table
   always_comb begin
      case (TBL_IDX)
         6'd0:    begin TBL_ADDR = 7'h08; TBL_MASK = 16'h1000; TBL_DATA = 16'h0145; end
         6'd1:    begin TBL_ADDR = 7'h09; TBL_MASK = 16'hFF00; TBL_DATA = 16'h00A5; end
         6'd32:   begin TBL_ADDR = 7'h14; TBL_MASK = 16'h00FF; TBL_DATA = 16'hBE00; end
         6'd33:   begin TBL_ADDR = 7'h15; TBL_MASK = 16'h0000; TBL_DATA = 16'h1234; end
         default: begin TBL_ADDR = 7'h7F; TBL_MASK = 16'hFFFF; TBL_DATA = 16'h0000; end
      endcase
   end

   function automatic logic [15:0] rd_val(input logic [6:0] a);
      case (a)
         7'h08:   return 16'h1FFF;
         7'h09:   return 16'h5A5A;
         7'h14:   return 16'hC3C3;
         7'h15:   return 16'hFFFF;
         default: return 16'h0000;
      endcase
   endfunction

   // DRP responder: DRDY drops for two cycles after each DEN.
   int          den_cnt  = 0;
   int          den_viol = 0;
   int          lat_cnt  = 0;
   bit          drp_hang = 1'b0;
   bit          prev_den = 1'b0;
   logic [5:0]  idx_log  [256];
   logic [6:0]  addr_log [256];
   logic        we_log   [256];
   logic [15:0] di_log   [256];

   always @(negedge DCLK) begin
      if (DEN === 1'b1) begin
         if (prev_den || (DRDY !== 1'b1)) den_viol++;
         if (den_cnt < 256) begin
            idx_log[den_cnt[7:0]]  = TBL_IDX;
            addr_log[den_cnt[7:0]] = DADDR;
            we_log[den_cnt[7:0]]   = DWE;
            di_log[den_cnt[7:0]]   = DI;
         end
         den_cnt++;
         if (DWE !== 1'b1) DO = rd_val(DADDR);
         DRDY    = 1'b0;
         lat_cnt = 2;
      end else if ((lat_cnt > 0) && !drp_hang) begin
         lat_cnt--;
         if (lat_cnt == 0) DRDY = 1'b1;
      end
      prev_den = (DEN === 1'b1);
   end

   // SRDY pulse monitor
   int srdy_total = 0;
   int srdy_viol  = 0;
   bit prev_srdy  = 1'b0;
   always @(negedge DCLK) begin
      if (SRDY === 1'b1) begin
         srdy_total++;
         if (prev_srdy) srdy_viol++;
      end
      prev_srdy = (SRDY === 1'b1);
   end

   // Packs four logged transactions {we, addr, data-if-write}, oldest first.
   function automatic logic [95:0] txn4(input int b);
      logic [95:0] r;
      logic [7:0]  k;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         k = 8'(b + i);
         r = {r[71:0], we_log[k], addr_log[k], (we_log[k] ? di_log[k] : 16'h0000)};
      end
      return r;
   endfunction

   function automatic logic [23:0] idx4(input int b);
      logic [23:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) r = {r[17:0], idx_log[8'(b + i)]};
      return r;
   endfunction

   localparam logic [95:0] c_txn_set0 = {1'b0, 7'h08, 16'h0000, 1'b1, 7'h08, 16'h1145,
                                         1'b0, 7'h09, 16'h0000, 1'b1, 7'h09, 16'h5AA5};
   localparam logic [95:0] c_txn_set1 = {1'b0, 7'h14, 16'h0000, 1'b1, 7'h14, 16'hBEC3,
                                         1'b0, 7'h15, 16'h0000, 1'b1, 7'h15, 16'h1234};

   task automatic tick(input int n);
      repeat (n) @(negedge DCLK);
   endtask

   task automatic start(input logic [CFG_W-1:0] s);
      SEN  = 1'b1;
      SSEL = s;
      tick(1);
      SEN  = 1'b0;
   endtask

   // Returns at the first negedge of LOCK_WAIT (busy with the PLL released).
   task automatic wait_lockwait(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if ((BUSY === 1'b1) && (RST_PLL === 1'b0)) begin ok = 1'b1; break; end
         tick(1);
      end
   endtask

   task automatic wait_den(input logic we, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if ((DEN === 1'b1) && (DWE === we)) begin ok = 1'b1; break; end
         tick(1);
      end
   endtask

   task automatic test_reset();
      bit bad;
      RST = 1'b1; LOCKED = 1'b0; SEN = 1'b0;
      tick(2);
      checks++; if (DEN !== 1'b0)     begin errors++; $display("FAIL rst_den got %b exp 0", DEN); end
      checks++; if (DWE !== 1'b0)     begin errors++; $display("FAIL rst_dwe got %b exp 0", DWE); end
      checks++; if (DADDR !== 7'h00)  begin errors++; $display("FAIL rst_daddr got %h exp 00", DADDR); end
      checks++; if (DI !== 16'h0000)  begin errors++; $display("FAIL rst_di got %h exp 0000", DI); end
      checks++; if (SRDY !== 1'b0)    begin errors++; $display("FAIL rst_srdy got %b exp 0", SRDY); end
      checks++; if (BUSY !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b exp 0", BUSY); end
      checks++; if (ERR !== 1'b0)     begin errors++; $display("FAIL rst_err got %b exp 0", ERR); end
      checks++; if (TBL_IDX !== 6'd0) begin errors++; $display("FAIL rst_idx got %h exp 00", TBL_IDX); end
      checks++; if (RST_PLL !== 1'b1) begin errors++; $display("FAIL rst_rst_pll got %b exp 1", RST_PLL); end
      RST = 1'b0;
      tick(1);
      checks++; if (RST_PLL !== 1'b0) begin errors++; $display("FAIL waitlock_rst_pll got %b exp 0", RST_PLL); end
      // SEN in WAIT_LOCK is ignored; no timeout in WAIT_LOCK either.
      SEN = 1'b1; tick(1); SEN = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if ((BUSY !== 1'b0) || (ERR !== 1'b0) || (DEN !== 1'b0)) bad = 1'b1;
         tick(1);
      end
      checks++; if (bad) begin errors++; $display("FAIL waitlock_idle got activity exp none"); end
      LOCKED = 1'b1;
      tick(3);
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL sen_not_queued busy got %b exp 0", BUSY); end
   endtask

   task automatic test_basic();
      int  base, sb;
      bit  ok, bad;
      LOCKED = 1'b0;
      base = den_cnt; sb = srdy_total;
      start(1'b0);
      checks++; if ({BUSY, RST_PLL, ERR} !== 3'b110) begin errors++; $display("FAIL basic_accept busy/rst_pll/err got %b exp 110", {BUSY, RST_PLL, ERR}); end
      wait_lockwait(ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_release got timeout exp lock_wait"); end
      checks++; if (den_cnt - base != 4) begin errors++; $display("FAIL basic_den_count got %0d exp 4", den_cnt - base); end
      checks++; if (txn4(base) !== c_txn_set0) begin errors++; $display("FAIL basic_txn got %h exp %h", txn4(base), c_txn_set0); end
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if ((SRDY !== 1'b0) || (BUSY !== 1'b1)) bad = 1'b1;
         if (i == 4) LOCKED = 1'b1;
         tick(1);
      end
      checks++; if (bad) begin errors++; $display("FAIL basic_early_srdy got srdy/busy change exp none"); end
      checks++; if ({SRDY, BUSY, ERR} !== 3'b100) begin errors++; $display("FAIL basic_done srdy/busy/err got %b exp 100", {SRDY, BUSY, ERR}); end
      tick(1);
      checks++; if (SRDY !== 1'b0) begin errors++; $display("FAIL basic_srdy_width got %b exp 0", SRDY); end
      checks++; if (srdy_total - sb != 1) begin errors++; $display("FAIL basic_srdy_count got %0d exp 1", srdy_total - sb); end
   endtask

   task automatic test_sen_ignored();
      int base, sb;
      bit ok;
      LOCKED = 1'b1;   // must be ignored until LOCK_WAIT
      base = den_cnt; sb = srdy_total;
      start(1'b0);
      wait_den(1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL sen2_first_den got timeout exp den"); end
      SEN = 1'b1; SSEL = 1'b1; tick(1); SEN = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (SRDY === 1'b1) begin ok = 1'b1; break; end
         tick(1);
      end
      checks++; if (!ok) begin errors++; $display("FAIL sen2_srdy got timeout exp srdy"); end
      checks++; if (den_cnt - base != 4) begin errors++; $display("FAIL sen2_den_count got %0d exp 4", den_cnt - base); end
      checks++; if (idx4(base) !== {6'd0, 6'd0, 6'd1, 6'd1}) begin errors++; $display("FAIL sen2_idx_seq got %h exp %h", idx4(base), {6'd0, 6'd0, 6'd1, 6'd1}); end
      tick(20);
      checks++; if (srdy_total - sb != 1) begin errors++; $display("FAIL sen2_srdy_count got %0d exp 1", srdy_total - sb); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL sen2_not_queued busy got %b exp 0", BUSY); end
      SSEL = 1'b0;
      LOCKED = 1'b0;   // falling LOCKED in IDLE: no action
      tick(3);
      checks++; if ({BUSY, RST_PLL, ERR} !== 3'b000) begin errors++; $display("FAIL idle_locked_fall got %b exp 000", {BUSY, RST_PLL, ERR}); end
   endtask

   task automatic test_drp_timeout();
      int base, sb;
      bit ok, bad;
      LOCKED = 1'b0; drp_hang = 1'b1;
      base = den_cnt; sb = srdy_total;
      start(1'b0);
      wait_den(1'b0, ok);   // first cycle of RD_WAIT
      checks++; if (!ok) begin errors++; $display("FAIL tmo_first_den got timeout exp den"); end
      bad = 1'b0;
      for (int i = 0; i < 254; i++) begin
         tick(1);
         if ((ERR !== 1'b0) || (BUSY !== 1'b1) || (RST_PLL !== 1'b1)) bad = 1'b1;
      end
      checks++; if (bad) begin errors++; $display("FAIL tmo_early_abort got abort before 255 exp none"); end
      tick(1);
      checks++; if ({ERR, RST_PLL, BUSY, DEN} !== 4'b1000) begin errors++; $display("FAIL tmo_abort err/rst_pll/busy/den got %b exp 1000", {ERR, RST_PLL, BUSY, DEN}); end
      checks++; if (srdy_total != sb) begin errors++; $display("FAIL tmo_srdy got %0d pulses exp 0", srdy_total - sb); end
      drp_hang = 1'b0;
      tick(5);
      checks++; if ((den_cnt - base != 1) || (ERR !== 1'b1)) begin errors++; $display("FAIL tmo_idle den_count %0d err %b exp 1 1", den_cnt - base, ERR); end
   endtask

   task automatic test_reset_mid();
      int base;
      bit ok;
      LOCKED = 1'b0;
      start(1'b0);
      wait_den(1'b1, ok);   // first cycle of WR_WAIT
      checks++; if (!ok) begin errors++; $display("FAIL rmid_wr_den got timeout exp den"); end
      #2 RST = 1'b1;
      #1;
      checks++; if ({DEN, BUSY, RST_PLL} !== 3'b001) begin errors++; $display("FAIL rmid_async den/busy/rst_pll got %b exp 001", {DEN, BUSY, RST_PLL}); end
      tick(2);
      RST = 1'b0;
      tick(1);
      checks++; if (RST_PLL !== 1'b0) begin errors++; $display("FAIL rmid_waitlock rst_pll got %b exp 0", RST_PLL); end
      tick(3);
      LOCKED = 1'b1; tick(2); LOCKED = 1'b0;
      base = den_cnt;
      start(1'b0);
      wait_lockwait(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rmid_rerun got timeout exp lock_wait"); end
      checks++; if (txn4(base) !== c_txn_set0) begin errors++; $display("FAIL rmid_txn got %h exp %h", txn4(base), c_txn_set0); end
      LOCKED = 1'b1; tick(1);
      checks++; if (SRDY !== 1'b1) begin errors++; $display("FAIL rmid_srdy got %b exp 1", SRDY); end
      tick(1);
   endtask

   task automatic test_lock_wait();
      int sb;
      bit ok, bad;
      LOCKED = 1'b0; sb = srdy_total;
      start(1'b0);
      wait_lockwait(ok);
      checks++; if (!ok) begin errors++; $display("FAIL lock_release got timeout exp lock_wait"); end
      bad = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if ((SRDY !== 1'b0) || (BUSY !== 1'b1)) bad = 1'b1;
         if (i == 99) LOCKED = 1'b1;
         tick(1);
      end
      checks++; if (bad) begin errors++; $display("FAIL lock_hold got early srdy exp none"); end
      checks++; if (SRDY !== 1'b1) begin errors++; $display("FAIL lock_srdy got %b exp 1", SRDY); end
      tick(1);
      checks++; if (srdy_total - sb != 1) begin errors++; $display("FAIL lock_srdy_count got %0d exp 1", srdy_total - sb); end
      // LOCKED never rises: LOCK_WAIT timeout.
      LOCKED = 1'b0; sb = srdy_total;
      start(1'b0);
      wait_lockwait(ok);
      checks++; if (!ok) begin errors++; $display("FAIL lock2_release got timeout exp lock_wait"); end
      bad = 1'b0;
      for (int i = 0; i < 255; i++) begin
         if ((ERR !== 1'b0) || (BUSY !== 1'b1) || (SRDY !== 1'b0)) bad = 1'b1;
         tick(1);
      end
      checks++; if (bad) begin errors++; $display("FAIL lock2_early got abort before 255 exp none"); end
      checks++; if ({ERR, BUSY, RST_PLL} !== 3'b100) begin errors++; $display("FAIL lock2_abort err/busy/rst_pll got %b exp 100", {ERR, BUSY, RST_PLL}); end
      checks++; if (srdy_total != sb) begin errors++; $display("FAIL lock2_srdy got %0d pulses exp 0", srdy_total - sb); end
   endtask

   task automatic test_ssel_err();
      int base;
      bit ok;
      checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL ssel_prior_err got %b exp 1", ERR); end
      LOCKED = 1'b0; base = den_cnt;
      start(1'b1);
      SSEL = 1'b0;   // change while busy must have no effect
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL ssel_err_clear got %b exp 0", ERR); end
      wait_lockwait(ok);
      checks++; if (!ok) begin errors++; $display("FAIL ssel_release got timeout exp lock_wait"); end
      checks++; if (idx4(base) !== {6'd32, 6'd32, 6'd33, 6'd33}) begin errors++; $display("FAIL ssel_idx_seq got %h exp %h", idx4(base), {6'd32, 6'd32, 6'd33, 6'd33}); end
      checks++; if (txn4(base) !== c_txn_set1) begin errors++; $display("FAIL ssel_txn got %h exp %h", txn4(base), c_txn_set1); end
      LOCKED = 1'b1; tick(1);
      checks++; if ({SRDY, ERR} !== 2'b10) begin errors++; $display("FAIL ssel_done srdy/err got %b exp 10", {SRDY, ERR}); end
      tick(2);
   endtask

   task automatic test_protocol();
      checks++; if (den_viol != 0)  begin errors++; $display("FAIL den_protocol got %0d violations exp 0", den_viol); end
      checks++; if (srdy_viol != 0) begin errors++; $display("FAIL srdy_width got %0d violations exp 0", srdy_viol); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sen_ignored();
      test_drp_timeout();
      test_reset_mid();
      test_lock_wait();
      test_ssel_err();
      test_protocol();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
